// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared types, range encodings and gate-length helper for the frequency meter
package freq_meter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        GATE,
        SETTLE,
        LATCH
    } state_t;

    localparam logic [1:0] RANGE_10MS  = 2'b00;
    localparam logic [1:0] RANGE_100MS = 2'b01;
    localparam logic [1:0] RANGE_1S    = 2'b10;

    localparam int unsigned AR_LO_THR = 1000;

    // Gate length in clk cycles; the reserved encoding falls through to 1 s.
    function automatic int unsigned gate_cycles(input logic [1:0] rng, input int unsigned clk_hz);
        case (rng)
            RANGE_10MS:  return clk_hz / 100;
            RANGE_100MS: return clk_hz / 10;
            default:     return clk_hz;
        endcase
    endfunction

endpackage

// File: rtl/freq_gate_ctrl_if.sv
// rtl/freq_gate_ctrl_if.sv - control/result bundle between the measurement sequencer and its environment
interface freq_gate_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             start;
    logic             cont;
    logic [1:0]       range_sel;
    logic [CNT_W-1:0] count_in;
    logic             gate;
    logic             cnt_clr;
    logic [CNT_W-1:0] freq_out;
    logic             freq_valid;
    logic             busy;
    logic             ovf;
    logic [1:0]       range_act;

    modport master (
        input  start, cont, range_sel, count_in,
        output gate, cnt_clr, freq_out, freq_valid, busy, ovf, range_act
    );

    modport slave (
        output start, cont, range_sel, count_in,
        input  gate, cnt_clr, freq_out, freq_valid, busy, ovf, range_act
    );
endinterface

// File: rtl/freq_gate_ctrl_gate_timer.sv
// rtl/freq_gate_ctrl_gate_timer.sv - loadable down-counter timing the gate and settle intervals
module gate_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         run,
    output logic         done
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (run && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/freq_gate_ctrl.sv
// rtl/freq_gate_ctrl.sv - frequency meter measurement sequencer: clear, gate, settle, latch and scale to Hz
// Optional build macro FREQ_AUTORANGE_EN: range steps automatically after the first measurement.
module freq_gate_ctrl
    import freq_meter_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int CNT_W      = 32,
    parameter int SETTLE_CYC = 4
) (
    input logic             clk,
    input logic             rst,
    freq_gate_ctrl_if.master bus
);
    localparam int TW_GATE = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int TW_SET  = $clog2(SETTLE_CYC + 1);
    localparam int TW      = (TW_GATE > TW_SET) ? TW_GATE : TW_SET;

    state_t           state;
    logic             gate_q, cnt_clr_q, freq_valid_q, busy_q, ovf_q;
    logic [CNT_W-1:0] freq_q;
    logic [1:0]       range_act_q;

    logic [1:0]       sel_norm, meas_range;
    logic             t_load, t_run, t_done;
    logic [TW-1:0]    t_val;
    logic [6:0]       scale;
    logic [2*CNT_W-1:0] prod;
    logic             sat;

    assign sel_norm = (bus.range_sel == 2'b11) ? RANGE_1S : bus.range_sel;

`ifdef FREQ_AUTORANGE_EN
    // Once seeded from range_sel, the autorange logic owns range_act.
    logic ar_seeded;
    assign meas_range = ar_seeded ? range_act_q : sel_norm;
`else
    assign meas_range = sel_norm;
`endif

    assign t_load = (state == CLEAR) || (state == GATE && t_done);
    assign t_val  = (state == CLEAR) ? TW'(gate_cycles(meas_range, CLK_HZ) - 1)
                                     : TW'(SETTLE_CYC - 1);
    assign t_run  = (state == GATE) || (state == SETTLE);

    gate_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (t_load),
        .load_val (t_val),
        .run      (t_run),
        .done     (t_done)
    );

    always_comb begin
        scale = 7'd1;
        case (range_act_q)
            RANGE_10MS:  scale = 7'd100;
            RANGE_100MS: scale = 7'd10;
            default:     scale = 7'd1;
        endcase
    end

    assign prod = (2*CNT_W)'(bus.count_in) * (2*CNT_W)'(scale);
    assign sat  = |prod[2*CNT_W-1:CNT_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            gate_q       <= 1'b0;
            cnt_clr_q    <= 1'b0;
            freq_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            ovf_q        <= 1'b0;
            freq_q       <= '0;
            range_act_q  <= RANGE_1S;
`ifdef FREQ_AUTORANGE_EN
            ar_seeded    <= 1'b0;
`endif
        end else begin
            cnt_clr_q    <= 1'b0;
            freq_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start || bus.cont) begin
                        state     <= CLEAR;
                        cnt_clr_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                CLEAR: begin
                    state       <= GATE;
                    gate_q      <= 1'b1;
                    range_act_q <= meas_range;
`ifdef FREQ_AUTORANGE_EN
                    ar_seeded   <= 1'b1;
`endif
                end
                GATE: begin
                    if (t_done) begin
                        state  <= SETTLE;
                        gate_q <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (t_done) begin
                        state <= LATCH;
                    end
                end
                LATCH: begin
                    freq_q       <= sat ? '1 : prod[CNT_W-1:0];
                    ovf_q        <= sat;
                    freq_valid_q <= 1'b1;
`ifdef FREQ_AUTORANGE_EN
                    if (sat && range_act_q != RANGE_10MS) begin
                        range_act_q <= range_act_q - 2'd1;
                    end else if (bus.count_in < CNT_W'(AR_LO_THR) && range_act_q < RANGE_1S) begin
                        range_act_q <= range_act_q + 2'd1;
                    end
`endif
                    if (bus.cont) begin
                        state     <= CLEAR;
                        cnt_clr_q <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gate       = gate_q;
    assign bus.cnt_clr    = cnt_clr_q;
    assign bus.freq_out   = freq_q;
    assign bus.freq_valid = freq_valid_q;
    assign bus.busy       = busy_q;
    assign bus.ovf        = ovf_q;
    assign bus.range_act  = range_act_q;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// tb/tb_freq_gate_ctrl.sv - directed self-checking bench for freq_gate_ctrl at CLK_HZ=10000
module tb_freq_gate_ctrl;
    localparam int CLK_HZ = 10000;
    localparam int CNT_W  = 32;
    localparam int SC     = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    freq_gate_ctrl_if #(.CNT_W(CNT_W)) bus ();

    freq_gate_ctrl #(
        .CLK_HZ     (CLK_HZ),
        .CNT_W      (CNT_W),
        .SETTLE_CYC (SC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic quiet(input string tag, input int ncyc);
        int fv = 0;
        int bz = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (bus.freq_valid) fv++;
            if (bus.busy) bz++;
        end
        chk({tag, "_no_valid"}, 32'(fv), 32'd0);
        chk({tag, "_idle"}, 32'(bz), 32'd0);
    endtask

    // One start-triggered measurement; pert_t>0 pulses start and flips range_sel mid-gate.
    task automatic run_meas(input string tag, input logic [1:0] rs, input logic [31:0] cnt,
                            input int n, input logic [31:0] exp_f, input logic exp_o,
                            input logic [1:0] exp_ra, input int pert_t);
        int clr_n = 0;
        int gate_n = 0;
        int lat = -1;
        bus.range_sel = rs;
        bus.count_in  = cnt;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int t = 1; t <= n + 50; t++) begin
            if (pert_t > 0 && t == pert_t) begin
                bus.start     = 1'b1;
                bus.range_sel = rs ^ 2'b01;
            end
            if (pert_t > 0 && t == pert_t + 1) bus.start = 1'b0;
            if (bus.cnt_clr) clr_n++;
            if (bus.gate) gate_n++;
            if (bus.freq_valid) begin
                lat = t - 1;
                break;
            end
            @(negedge clk);
        end
        bus.range_sel = rs;
        chk({tag, "_clr"}, 32'(clr_n), 32'd1);
        chk({tag, "_gate_len"}, 32'(gate_n), 32'(n));
        chk({tag, "_latency"}, 32'(lat), 32'(n + SC + 2));
        chk({tag, "_freq"}, bus.freq_out, exp_f);
        chk({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_o));
        chk({tag, "_range_act"}, 32'(bus.range_act), 32'(exp_ra));
        chk({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int lat;
        bus.start     = 1'b0;
        bus.cont      = 1'b0;
        bus.range_sel = 2'b10;
        bus.count_in  = '0;
        repeat (3) @(negedge clk);
        chk("rst_gate", 32'(bus.gate), 32'd0);
        chk("rst_clr", 32'(bus.cnt_clr), 32'd0);
        chk("rst_freq", bus.freq_out, 32'd0);
        chk("rst_valid", 32'(bus.freq_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        chk("rst_range", 32'(bus.range_act), 32'd2);
        rst = 1'b0;
        @(negedge clk);

`ifdef FREQ_AUTORANGE_EN
        begin
            int exp_lat [3] = '{107, 1006, 10006};
            logic [31:0] exp_f [3] = '{32'd500, 32'd50, 32'd5};
            logic [1:0] exp_ra [3] = '{2'd1, 2'd2, 2'd2};
            bus.range_sel = 2'b00;
            bus.count_in  = 32'd5;
            bus.cont      = 1'b1;
            for (int i = 0; i < 3; i++) begin
                lat = -1;
                for (int k = 1; k <= 10100; k++) begin
                    @(negedge clk);
                    if (bus.freq_valid) begin
                        lat = k;
                        break;
                    end
                end
                if (i == 1) bus.cont = 1'b0;
                chk($sformatf("ar%0d_latency", i), 32'(lat), 32'(exp_lat[i]));
                chk($sformatf("ar%0d_freq", i), bus.freq_out, exp_f[i]);
                chk($sformatf("ar%0d_range", i), 32'(bus.range_act), 32'(exp_ra[i]));
            end
            chk("ar_busy_end", 32'(bus.busy), 32'd0);
            quiet("ar_after", 20);
        end
`else
        run_meas("r1s", 2'b10, 32'd1234, 10000, 32'd1234, 1'b0, 2'd2, 0);
        run_meas("r10ms", 2'b00, 32'd42, 100, 32'd4200, 1'b0, 2'd0, 0);
        run_meas("r100ms", 2'b01, 32'd42, 1000, 32'd420, 1'b0, 2'd1, 0);
        run_meas("big_ok", 2'b00, 32'h0200_0000, 100, 32'hC800_0000, 1'b0, 2'd0, 0);
        run_meas("edge_ok", 2'b00, 32'h028F_5C28, 100, 32'hFFFF_FFA0, 1'b0, 2'd0, 0);
        run_meas("sat", 2'b00, 32'h028F_5C29, 100, 32'hFFFF_FFFF, 1'b1, 2'd0, 0);
        run_meas("r100_sat", 2'b01, 32'hFFFF_FFFF, 1000, 32'hFFFF_FFFF, 1'b1, 2'd1, 0);
        run_meas("rsv", 2'b11, 32'd5, 10000, 32'd5, 1'b0, 2'd2, 0);
        run_meas("pert", 2'b00, 32'd9, 100, 32'd900, 1'b0, 2'd0, 50);
        quiet("pert_after", 20);

        bus.range_sel = 2'b00;
        bus.count_in  = 32'd7;
        bus.cont      = 1'b1;
        lat = -1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (bus.freq_valid) begin
                lat = k;
                break;
            end
        end
        chk("cont1_latency", 32'(lat), 32'd107);
        chk("cont1_freq", bus.freq_out, 32'd700);
        chk("cont1_reclear", 32'(bus.cnt_clr), 32'd1);
        chk("cont1_busy", 32'(bus.busy), 32'd1);
        repeat (50) @(negedge clk);
        chk("cont2_gate", 32'(bus.gate), 32'd1);
        bus.cont = 1'b0;
        lat = -1;
        for (int k = 51; k <= 300; k++) begin
            @(negedge clk);
            if (bus.freq_valid) begin
                lat = k;
                break;
            end
        end
        chk("cont2_latency", 32'(lat), 32'd106);
        chk("cont2_freq", bus.freq_out, 32'd700);
        chk("cont2_busy", 32'(bus.busy), 32'd0);
        chk("cont2_noclr", 32'(bus.cnt_clr), 32'd0);
        quiet("cont_after", 20);

        bus.range_sel = 2'b01;
        bus.count_in  = 32'd42;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (30) @(negedge clk);
        chk("rstg_gate_on", 32'(bus.gate), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstg_gate", 32'(bus.gate), 32'd0);
        chk("rstg_busy", 32'(bus.busy), 32'd0);
        chk("rstg_freq", bus.freq_out, 32'd0);
        chk("rstg_valid", 32'(bus.freq_valid), 32'd0);
        chk("rstg_ovf", 32'(bus.ovf), 32'd0);
        quiet("rstg_after", 1200);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
